// File: rtl/tropang_pkg.sv
// Shared constants for the Tropical Angel ROM loader: region map, ioctl indices, loader states.
package tropang_pkg;

  localparam int NREG = 5;

  typedef enum logic [2:0] {
    REG_CPU,
    REG_SND,
    REG_TIL,
    REG_SPR,
    REG_PRM
  } region_e;

  localparam int unsigned REG_SIZE [NREG] = '{32768, 4096, 24576, 49152, 576};
  localparam int unsigned REG_BASE [NREG] = '{32'h00000, 32'h08000, 32'h09000, 32'h0F000, 32'h1B000};
  localparam int unsigned TOTAL_ROM = 32'h1B240;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_DIP = 8'd254;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK
  } load_state_e;

endpackage

// File: rtl/tropang_rom_loader_if.sv
// ioctl download stream in, per-region ROM write bus out.
interface tropang_rom_loader_if;
  logic                            ioctl_download;
  logic                            ioctl_wr;
  logic [24:0]                     ioctl_addr;
  logic [7:0]                      ioctl_dout;
  logic [7:0]                      ioctl_index;
  logic [tropang_pkg::NREG-1:0]    rom_we;
  logic [15:0]                     rom_addr;
  logic [7:0]                      rom_data;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    input  rom_we, rom_addr, rom_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
    output rom_we, rom_addr, rom_data
  );
endinterface

// File: rtl/tropang_region_decode.sv
// Combinational byte-address to one-hot region decode with in-region offset.
module tropang_region_decode
  import tropang_pkg::*;
#(
  parameter int unsigned BASE [NREG] = REG_BASE,
  parameter int unsigned SIZE [NREG] = REG_SIZE
) (
  input  logic            en,
  input  logic [24:0]     addr,
  output logic [NREG-1:0] sel,
  output logic [15:0]     offset,
  output logic            overrun
);

  logic hit;

  // Regions are contiguous and ascending, so the first end above addr wins.
  always_comb begin
    sel     = '0;
    offset  = '0;
    hit     = 1'b0;
    overrun = 1'b0;
    for (int k = 0; k < NREG; k++) begin
      if (!hit && (addr < 25'(BASE[k] + SIZE[k]))) begin
        sel[k] = en;
        offset = 16'(addr - 25'(BASE[k]));
        hit    = 1'b1;
      end
    end
    overrun = en && !hit;
  end

endmodule

// File: rtl/tropang_rom_loader.sv
// Routes ioctl ROM/DIP downloads to region write ports and gates core reset on a complete ROM set.
// Optional TROPANG_ROM_SUM_EN adds a 16-bit additive checksum output rom_sum.
//
// state   | meaning
// IDLE    | waiting for a ROM download; core_reset follows !rom_ok
// LOAD    | ROM bytes streaming; counters and overrun flag accumulate
// CHECK   | one cycle: judge counters and overrun, publish rom_ok/rom_err
module tropang_rom_loader
  import tropang_pkg::*;
#(
  parameter int unsigned CPU_SIZE = REG_SIZE[REG_CPU],
  parameter int unsigned SND_SIZE = REG_SIZE[REG_SND],
  parameter int unsigned TIL_SIZE = REG_SIZE[REG_TIL],
  parameter int unsigned SPR_SIZE = REG_SIZE[REG_SPR],
  parameter int unsigned PRM_SIZE = REG_SIZE[REG_PRM]
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  tropang_rom_loader_if.slave io,
  output logic [63:0]         dip_sw,
  output logic                rom_ok,
  output logic                rom_err,
  output logic                core_reset
`ifdef TROPANG_ROM_SUM_EN
  ,
  output logic [15:0]         rom_sum
`endif
);

  localparam int unsigned SIZE [NREG] = '{CPU_SIZE, SND_SIZE, TIL_SIZE, SPR_SIZE, PRM_SIZE};
  localparam int unsigned BASE [NREG] = '{0, CPU_SIZE, CPU_SIZE + SND_SIZE,
                                          CPU_SIZE + SND_SIZE + TIL_SIZE,
                                          CPU_SIZE + SND_SIZE + TIL_SIZE + SPR_SIZE};

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_CHECK = ST_CHECK;

  logic [1:0]      state;
  logic            dl_q;
  logic            overrun;
  logic [NREG-1:0] sel;
  logic [NREG-1:0] wr_sel;
  logic [NREG-1:0] full;
  logic [15:0]     offset;
  logic            ovr_hit;
  logic            rom_sel;
  logic            rise;
  logic            fall;
  logic            enter_load;
  logic            ovr_wr;
  logic            dip_wr;
  logic            load_ok;

  assign rom_sel    = io.ioctl_download && (io.ioctl_index == IDX_ROM);
  assign wr_sel     = {NREG{io.ioctl_wr}} & sel;
  assign ovr_wr     = io.ioctl_wr && ovr_hit;
  assign rise       = io.ioctl_download && !dl_q;
  assign fall       = !io.ioctl_download && dl_q;
  assign enter_load = (state == S_IDLE) && rise && (io.ioctl_index == IDX_ROM);
  assign dip_wr     = io.ioctl_wr && (io.ioctl_index == IDX_DIP) && (io.ioctl_addr[24:3] == 22'd0);
  assign load_ok    = (&full) && !overrun;

  tropang_region_decode #(
    .BASE (BASE),
    .SIZE (SIZE)
  ) u_decode (
    .en      (rom_sel),
    .addr    (io.ioctl_addr),
    .sel     (sel),
    .offset  (offset),
    .overrun (ovr_hit)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      io.rom_we   <= '0;
      io.rom_addr <= '0;
      io.rom_data <= '0;
      dip_sw      <= '0;
      dl_q        <= 1'b0;
    end else begin
      io.rom_we <= wr_sel;
      dl_q      <= io.ioctl_download;
      if (|wr_sel) begin
        io.rom_addr <= offset;
        io.rom_data <= io.ioctl_dout;
      end
      if (dip_wr) dip_sw[{io.ioctl_addr[2:0], 3'b000} +: 8] <= io.ioctl_dout;
    end
  end

  // Byte counters saturate at the region size; a strobe on the LOAD entry cycle counts as the first byte.
  for (genvar k = 0; k < NREG; k++) begin : g_cnt
    localparam int W = $clog2(SIZE[k]) + 1;
    localparam logic [W-1:0] FULL = W'(SIZE[k]);
    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (enter_load) begin
        cnt <= wr_sel[k] ? W'(1) : '0;
      end else if (wr_sel[k] && (cnt != FULL)) begin
        cnt <= cnt + W'(1);
      end
    end

    assign full[k] = (cnt == FULL);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      overrun    <= 1'b0;
      rom_ok     <= 1'b0;
      rom_err    <= 1'b0;
      core_reset <= 1'b1;
    end else begin
      if (io.ioctl_download || (state != S_IDLE)) core_reset <= 1'b1;
      else                                        core_reset <= !rom_ok;

      if (enter_load)  overrun <= ovr_wr;
      else if (ovr_wr) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (enter_load) begin
            state   <= S_LOAD;
            rom_ok  <= 1'b0;
            rom_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (fall) state <= S_CHECK;
        end
        S_CHECK: begin
          rom_ok  <= load_ok;
          rom_err <= !load_ok;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TROPANG_ROM_SUM_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rom_sum <= '0;
    end else if (enter_load) begin
      rom_sum <= (|wr_sel) ? {8'h00, io.ioctl_dout} : 16'h0000;
    end else if ((state == S_LOAD) && (|wr_sel)) begin
      rom_sum <= rom_sum + {8'h00, io.ioctl_dout};
    end
  end
`endif

endmodule

// File: doc/tropang_rom_loader.md
Name: tropang_rom_loader

Overview:
- Sits between the hps_io ioctl download stream and the Tropical Angel core.
- Routes index-0 ROM bytes into five region write ports: main CPU, sound CPU, tile GFX, sprite GFX and PROM.
- Latches index-254 DIP bytes into a 64-bit vector.
- Counts bytes per region, flags complete/incomplete loads, and gates core reset until a good ROM set is in place.

Parameters:
- CPU_SIZE, 32768, main CPU ROM bytes, region 0, base 0x00000.
- SND_SIZE, 4096, sound CPU ROM bytes, region 1, base follows region 0.
- TIL_SIZE, 24576, tile GFX bytes, region 2.
- SPR_SIZE, 49152, sprite GFX bytes, region 3.
- PRM_SIZE, 576, colour PROM bytes, region 4.
- Region bases are cumulative: 0x00000, 0x08000, 0x09000, 0x0F000, 0x1B000. Total size is 0x1B240.

Ports:
- clk_sys  in  1  system clock, 36.864 MHz.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  byte write strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- ioctl_index  in  8  0 = ROM, 254 = DIP.
- rom_we  out  5  one-hot region write strobe.
- rom_addr  out  16  offset within the selected region.
- rom_data  out  8  write data.
- dip_sw  out  64  DIP bytes, byte n at bits [8n+7:8n].
- rom_ok  out  1  last ROM download was complete.
- rom_err  out  1  last ROM download was short or overran.
- core_reset  out  1  active-high reset to the core.

Behaviour:
- Reset values: rom_we=0, rom_addr=0, rom_data=0, dip_sw=0, rom_ok=0, rom_err=0, core_reset=1. All per-region counters are 0. State is IDLE.
- Write path:
  - The write path is registered, with exactly 1 cycle of latency from ioctl_wr to rom_we.
  - rom_we is a single-cycle pulse with at most one bit set.
  - rom_addr = ioctl_addr minus the region base, truncated to 16 bits. rom_data = ioctl_dout.
- Region decode applies only when index=0 and ioctl_download=1.
  - Region k is selected when base_k <= addr < base_k+size_k.
  - An address >= 0x1B240 produces no strobe and sets the sticky overrun flag.
- DIP path:
  - When index=254, ioctl_wr=1 and ioctl_addr[24:3]=0, write dip_sw byte addr[2:0] at the next edge.
  - Any other DIP address is ignored.
  - A DIP write never affects rom_we, the counters or the ROM state machine.
- Counters:
  - Each region has a counter of width clog2(size)+1. It increments on each strobe into that region and saturates at size.
  - Duplicate addresses are counted, so each counter counts bytes written, not unique addresses.
- State machine, states IDLE, LOAD, CHECK:
  - IDLE -> LOAD on a rising edge of ioctl_download with index=0. Entering LOAD clears the counters, the overrun flag, rom_ok and rom_err, and sets core_reset=1.
  - LOAD -> CHECK on a falling edge of ioctl_download.
  - CHECK lasts 1 cycle.
    - If every counter equals its size and overrun=0: set rom_ok=1, rom_err=0.
    - Otherwise: set rom_ok=0, rom_err=1.
    - Then go to IDLE.
  - In IDLE, core_reset = !rom_ok.
  - A rising edge of ioctl_download with index!=0 (DIP or other) leaves the state unchanged. core_reset is forced to 1 while ioctl_download=1 regardless of index.
- Simultaneous events:
  - If the last ioctl_wr arrives in the same cycle that ioctl_download falls, that byte is still strobed and counted before CHECK evaluates. CHECK uses the counter values after this final strobe.
  - If index changes during LOAD, strobes stop. The counts are evaluated in CHECK.
- Reset mid-operation: asserting reset_n=0 in any state returns every output to its reset value immediately, including clearing dip_sw.
- Edge detection: uses a one-cycle registered copy of ioctl_download. Its reset value is 0.

Optional Feature:
- Macro: TROPANG_ROM_SUM_EN.
- When defined:
  - Adds output port rom_sum[15:0], a 16-bit modular additive sum of every strobed ROM byte. Overrun bytes are excluded.
  - rom_sum clears on entry to LOAD and is frozen from CHECK onward.
  - rom_sum resets to 0.
- When undefined: the port and adder are absent. All other behaviour is identical.

Decomposition:
- Package tropang_pkg holds:
  - region count constant NREG=5;
  - region enum REG_CPU, REG_SND, REG_TIL, REG_SPR, REG_PRM;
  - size and base localparam arrays;
  - TOTAL_ROM=0x1B240;
  - IDX_ROM=0, IDX_DIP=254;
  - loader state enum.
- One natural sub-module, tropang_region_decode: combinational address-to-region one-hot decode plus offset subtraction, instantiated once.

Test Plan:
1. Reset then full download of 0x1B240 sequential bytes (data = addr[7:0]).
   - Addr 0x08000 -> rom_we=00010, rom_addr=0, 1 cycle after ioctl_wr.
   - Addr 0x1B23F -> rom_we=10000, rom_addr=0x023F.
   - End -> rom_ok=1, rom_err=0, core_reset falls 1 cycle after CHECK.
2. Short download stopping at 0x1B000 -> rom_ok=0, rom_err=1, core_reset stays 1.
3. Full download plus an extra write at 0x1B240 -> no strobe for the extra byte, rom_err=1.
4. DIP download index=254, bytes 0x11..0x88 at addr 0-7, plus a write at addr 8 -> dip_sw=0x8877665544332211. The addr-8 write is ignored and rom_ok is unchanged.
5. reset_n pulsed low mid-LOAD at addr 0x5000 -> all outputs at reset values immediately. A following full download gives rom_ok=1.
6. With TROPANG_ROM_SUM_EN: download of 0x1B240 bytes of 0x01 -> rom_sum=0xB240.
